turn_scheduler: RTL and testbench

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/turn_scheduler.sv | 136 +++++++++++++
 tb/tb_turn_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - two-player turn scheduler with shop window and per-turn timeout
// Optional feature macro: ALT_FIRST_PLAYER_EN (alternate the first mover every round).
module turn_scheduler #(
   parameter int TURN_TIMEOUT = 16,
   parameter int SHOP_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       phase,
   input  logic       p1_req,
   input  logic       p2_req,
   input  logic [2:0] p1_action,
   input  logic [2:0] p2_action,
   input  logic       p1_ready,
   input  logic       p2_ready,
   output logic       turn,
   output logic       play_valid,
   output logic [2:0] play_action,
   output logic       start_round,
   output logic       p1_ack,
   output logic       p2_ack,
   output logic       p1_timeout,
   output logic       p2_timeout,
   output logic [7:0] turn_count
);

   typedef enum logic [1:0] {SHOP, START, TURN_WAIT, SETTLE} state_t;

   localparam logic [9:0] SHOP_LAST = 10'(SHOP_TIMEOUT - 1);
   localparam logic [7:0] TURN_LAST = 8'(TURN_TIMEOUT - 1);

   state_t     state;
   logic [9:0] shop_cnt;
   logic [7:0] turn_timer;
   logic       p1_rdy;
   logic       p2_rdy;
   logic       first_mover;
   logic       act_req;
   logic [2:0] act_action;
   logic       both_ready;

   // Only the active player's request and move code are ever considered
   assign act_req    = turn ? p2_req : p1_req;
   assign act_action = turn ? p2_action : p1_action;

   // A ready pulse arriving this cycle counts together with the sticky flag
   assign both_ready = (p1_rdy | p1_ready) & (p2_rdy | p2_ready);

   // Scheduler FSM; every output is a register and strobes default low each cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SHOP;
         turn        <= 1'b0;
         play_valid  <= 1'b0;
         play_action <= 3'd0;
         start_round <= 1'b0;
         p1_ack      <= 1'b0;
         p2_ack      <= 1'b0;
         p1_timeout  <= 1'b0;
         p2_timeout  <= 1'b0;
         turn_count  <= 8'd0;
         shop_cnt    <= 10'd0;
         turn_timer  <= 8'd0;
         p1_rdy      <= 1'b0;
         p2_rdy      <= 1'b0;
         first_mover <= 1'b0;
      end else begin
         play_valid  <= 1'b0;
         play_action <= 3'd0;
         start_round <= 1'b0;
         p1_ack      <= 1'b0;
         p2_ack      <= 1'b0;
         p1_timeout  <= 1'b0;
         p2_timeout  <= 1'b0;
         case (state)
            SHOP: begin
               if (both_ready || shop_cnt == SHOP_LAST) begin
                  start_round <= 1'b1;
                  p1_rdy      <= 1'b0;
                  p2_rdy      <= 1'b0;
                  shop_cnt    <= 10'd0;
                  turn_count  <= 8'd0;
                  state       <= START;
               end else begin
                  p1_rdy   <= p1_rdy | p1_ready;
                  p2_rdy   <= p2_rdy | p2_ready;
                  shop_cnt <= shop_cnt + 10'd1;
               end
            end
            START: begin
               if (!phase) begin
                  turn       <= first_mover;
                  turn_timer <= 8'd0;
                  state      <= TURN_WAIT;
`ifdef ALT_FIRST_PLAYER_EN
                  // Advances once per started round so the next round opens with the other player
                  first_mover <= ~first_mover;
`endif
               end
            end
            TURN_WAIT: begin
               if (phase) begin
                  turn_timer <= 8'd0;
                  state      <= SHOP;
               end else if (act_req) begin
                  play_valid  <= 1'b1;
                  play_action <= act_action;
                  p1_ack      <= ~turn;
                  p2_ack      <= turn;
                  state       <= SETTLE;
               end else if (turn_timer == TURN_LAST) begin
                  p1_timeout <= ~turn;
                  p2_timeout <= turn;
                  state      <= SETTLE;
               end else begin
                  turn_timer <= turn_timer + 8'd1;
               end
            end
            SETTLE: begin
               turn_timer <= 8'd0;
               if (phase) begin
                  state <= SHOP;
               end else begin
                  turn  <= ~turn;
                  state <= TURN_WAIT;
                  if (turn_count != 8'hFF) begin
                     turn_count <= turn_count + 8'd1;
                  end
               end
            end
            default: state <= SHOP;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - randomized self-checking bench for turn_scheduler
module tb_turn_scheduler;

   localparam int TT = 16;
   localparam int ST = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       phase = 1'b1;
   logic       p1_req = 1'b0;
   logic       p2_req = 1'b0;
   logic [2:0] p1_action = 3'd0;
   logic [2:0] p2_action = 3'd0;
   logic       p1_ready = 1'b0;
   logic       p2_ready = 1'b0;
   logic       turn;
   logic       play_valid;
   logic [2:0] play_action;
   logic       start_round;
   logic       p1_ack;
   logic       p2_ack;
   logic       p1_timeout;
   logic       p2_timeout;
   logic [7:0] turn_count;

   turn_scheduler #(.TURN_TIMEOUT(TT), .SHOP_TIMEOUT(ST)) dut (
      .clk(clk), .rst_n(rst_n), .phase(phase),
      .p1_req(p1_req), .p2_req(p2_req),
      .p1_action(p1_action), .p2_action(p2_action),
      .p1_ready(p1_ready), .p2_ready(p2_ready),
      .turn(turn), .play_valid(play_valid), .play_action(play_action),
      .start_round(start_round), .p1_ack(p1_ack), .p2_ack(p2_ack),
      .p1_timeout(p1_timeout), .p2_timeout(p2_timeout), .turn_count(turn_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   bit prev_rn = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: where the game is, how long things have lasted, and what should appear next
   bit       m_shop, m_await, m_settle, m_r1, m_r2, m_mover;
   int       m_elapsed, m_waited, m_count, m_rounds;
   bit       e_sr, e_pv, e_a1, e_a2, e_t1, e_t2;
   bit [2:0] e_pa;

   task automatic model_reset();
      m_shop = 1; m_await = 0; m_settle = 0; m_r1 = 0; m_r2 = 0; m_mover = 0;
      m_elapsed = 0; m_waited = 0; m_count = 0; m_rounds = 0;
      e_sr = 0; e_pv = 0; e_a1 = 0; e_a2 = 0; e_t1 = 0; e_t2 = 0; e_pa = 0;
   endtask

   task automatic model_clock();
      bit req;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_sr = 0; e_pv = 0; e_a1 = 0; e_a2 = 0; e_t1 = 0; e_t2 = 0; e_pa = 0;
      req = m_mover ? p2_req : p1_req;
      if (m_shop) begin
         m_r1 = m_r1 | p1_ready;
         m_r2 = m_r2 | p2_ready;
         if ((m_r1 && m_r2) || m_elapsed == ST - 1) begin
            e_sr = 1; m_shop = 0; m_await = 1; m_r1 = 0; m_r2 = 0;
            m_elapsed = 0; m_count = 0; m_rounds++;
         end else begin
            m_elapsed++;
         end
      end else if (m_await) begin
         if (!phase) begin
            m_await = 0; m_waited = 0;
`ifdef ALT_FIRST_PLAYER_EN
            m_mover = ((m_rounds - 1) % 2) != 0;
`else
            m_mover = 0;
`endif
         end
      end else if (m_settle) begin
         m_settle = 0;
         if (phase) m_shop = 1;
         else begin
            m_mover = !m_mover; m_waited = 0;
            m_count = (m_count < 255) ? m_count + 1 : 255;
         end
      end else begin
         if (phase) m_shop = 1;
         else if (req) begin
            e_pv = 1; e_pa = m_mover ? p2_action : p1_action;
            e_a1 = !m_mover; e_a2 = m_mover; m_settle = 1;
         end else if (m_waited == TT - 1) begin
            e_t1 = !m_mover; e_t2 = m_mover; m_settle = 1;
         end else begin
            m_waited++;
         end
      end
   endtask

   // One clock: optional async-reset check, model update on the edge, compare 1 time unit later
   task automatic step();
      if (!rst_n && prev_rn) begin
         #1;
         check_eq("async_reset", {turn, play_valid, play_action, start_round, p1_ack, p2_ack,
                                  p1_timeout, p2_timeout, turn_count}, 32'd0);
      end
      prev_rn = rst_n;
      @(posedge clk);
      model_clock();
      #1;
      check_eq("strobes", {start_round, play_valid, p1_ack, p2_ack, p1_timeout, p2_timeout},
               {e_sr, e_pv, e_a1, e_a2, e_t1, e_t2});
      check_eq("play_action", play_action, e_pa);
      check_eq("turn", turn, m_mover);
      check_eq("turn_count", turn_count, m_count);
   endtask

   task automatic random_run(input int cycles, input int req_pct);
      for (int i = 0; i < cycles; i++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 99) < 3) phase = ~phase;
         p1_ready = ($urandom_range(0, 99) < 4);
         p2_ready = ($urandom_range(0, 99) < 4);
         if (!p1_req && $urandom_range(0, 99) < req_pct) begin
            p1_req = 1; p1_action = 3'($urandom_range(0, 4));
         end
         if (!p2_req && $urandom_range(0, 99) < req_pct) begin
            p2_req = 1; p2_action = 3'($urandom_range(0, 4));
         end
         step();
         if (e_a1 || !rst_n) p1_req = 0;
         if (e_a2 || !rst_n) p2_req = 0;
      end
   endtask

   initial begin
      int first_sr, n_sr, n_ack, n_pv, to_at;
      model_reset();
      #2 rst_n = 0;
      #1 check_eq("reset_state", {turn, play_valid, play_action, start_round, p1_ack, p2_ack,
                                  p1_timeout, p2_timeout, turn_count}, 32'd0);
      repeat (3) step();

      // Ready pulses at cycles 3 and 5 -> start_round only in cycle 6; requests never acked in SHOP
      p1_req = 1; p1_action = 3'd2; p2_req = 1;
      rst_n = 1;
      first_sr = -1; n_sr = 0; n_ack = 0;
      for (int k = 0; k < 12; k++) begin
         p1_ready = (k == 3); p2_ready = (k == 5);
         step();
         if (start_round) begin n_sr++; if (first_sr < 0) first_sr = k + 1; end
         if (p1_ack || p2_ack) n_ack++;
      end
      check_eq("ready_sr_cycle", first_sr, 6);
      check_eq("ready_sr_count", n_sr, 1);
      check_eq("shop_no_ack", n_ack, 0);

      // No ready inputs -> start_round 64 cycles after release
      p1_req = 0; p2_req = 0; p1_ready = 0; p2_ready = 0;
      rst_n = 0;
      repeat (2) step();
      rst_n = 1;
      first_sr = -1; n_sr = 0;
      for (int k = 0; k < 80; k++) begin
         step();
         if (start_round) begin n_sr++; if (first_sr < 0) first_sr = k + 1; end
      end
      check_eq("timeout_sr_cycle", first_sr, 64);
      check_eq("timeout_sr_count", n_sr, 1);

      // P1 move with action 1
      phase = 0;
      step();
      check_eq("first_turn", turn, 0);
      p1_req = 1; p1_action = 3'd1;
      step();
      check_eq("mv_valid", play_valid, 1);
      check_eq("mv_action", play_action, 1);
      check_eq("mv_ack", {p1_ack, p2_ack}, 2'b10);
      check_eq("mv_turn", turn, 0);
      p1_req = 0;
      step();
      check_eq("mv_next_turn", turn, 1);
      check_eq("mv_count", turn_count, 1);

      // P2 turn with only p1_req held -> P2 forfeits after 16 cycles, then P1 is served
      p1_req = 1; p1_action = 3'd3;
      to_at = -1; n_pv = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (play_valid) n_pv++;
         if (p2_timeout) begin to_at = k + 1; break; end
      end
      check_eq("to_cycle", to_at, 16);
      check_eq("to_no_valid", n_pv, 0);
      step();
      check_eq("to_turn_back", turn, 0);
      step();
      check_eq("to_p1_ack", p1_ack, 1);
      check_eq("to_p1_action", play_action, 3);
      p1_req = 0;

      // Round won during SETTLE -> SHOP, then next round's first mover
      phase = 1;
      step();
      p1_ready = 1; p2_ready = 1;
      step();
      check_eq("won_start_round", start_round, 1);
      p1_ready = 0; p2_ready = 0; phase = 0;
      step();
`ifdef ALT_FIRST_PLAYER_EN
      check_eq("round2_first", turn, 1);
`else
      check_eq("round2_first", turn, 0);
`endif

      // Reset in the same cycle as a pending request
      p1_req = 1; p2_req = 1; rst_n = 0;
      step();
      check_eq("rst_no_move", {play_valid, p1_ack, p2_ack}, 3'b000);
      p1_req = 0; p2_req = 0;
      step();
      rst_n = 1; phase = 1;

      random_run(3000, 25);
      random_run(3000, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
